clic_irq_arbiter: RTL

- Sequential CLIC interrupt arbiter for the Sclic-enabled 64-bit core; it sits between the CLIC source register file and the core's CLIC interrupt interface.
- Sweeps the 256 sources a slice per cycle and keeps the best eligible candidate.
- Offers the sweep winner to the core with a valid/ready handshake.
- Withdraws a stale offer through a kill-request/ack handshake.

---
 rtl/clic_arb_pkg.sv | 47 ++++
 rtl/clic_slice_max.sv | 40 ++++
 rtl/clic_irq_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/clic_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clic_arb_pkg
// Purpose  : Shared types and ranking function for the CLIC interrupt arbiter.
//            The candidate struct is sized from the package constants below.
//            Retarget the source count or level width here, not only at the
//            top-level parameters.
// Contents : cand_t       - one interrupt candidate (valid, id, level, priv, shv)
//            arb_state_e  - arbiter FSM states (SCAN, OFFER, KILL)
//            better(a, b) - 1 when candidate a outranks candidate b
// Macro    : CLIC_ARB_PRIV_EN - when defined, privilege is the first ranking key
// Revision : 1.0 - initial release
// ============================================================================
package clic_arb_pkg;

  localparam int unsigned c_NUM_SRC = 256;
  localparam int unsigned c_LEVEL_W = 8;
  localparam int unsigned c_ID_W    = $clog2(c_NUM_SRC);

  typedef struct packed {
    logic                 valid;
    logic [c_ID_W-1:0]    id;
    logic [c_LEVEL_W-1:0] level;
    logic [1:0]           priv;
    logic                 shv;
  } cand_t;

  typedef enum logic [1:0] {
    ST_SCAN  = 2'd0,
    ST_OFFER = 2'd1,
    ST_KILL  = 2'd2
  } arb_state_e;

  // Ranking: a valid candidate beats an invalid one, then (optionally) higher
  // privilege, then higher level. The lower id wins a full tie.
  function automatic logic better(input cand_t a, input cand_t b);
    if (!a.valid) return 1'b0;
    if (!b.valid) return 1'b1;
`ifdef CLIC_ARB_PRIV_EN
    if (a.priv != b.priv) return (a.priv > b.priv);
`endif
    if (a.level != b.level) return (a.level > b.level);
    return (a.id < b.id);
  endfunction

endpackage
`default_nettype wire

// File: rtl/clic_slice_max.sv
`default_nettype none
// ============================================================================
// Module   : clic_slice_max
// Purpose  : Combinational binary max tree that picks the best candidate out
//            of one sweep slice using the shared ranking function.
// Ports    : i_cand - SrcPerCycle candidates, element k holds the k-th source
//                     of the slice (ascending id)
//            o_best - slice winner (valid=0 when no candidate is eligible)
// Macro    : CLIC_ARB_PRIV_EN (through clic_arb_pkg::better)
// Revision : 1.0 - initial release
// ============================================================================
module clic_slice_max
  import clic_arb_pkg::*;
#(
  parameter int unsigned SrcPerCycle = 8
) (
  input  cand_t [SrcPerCycle-1:0] i_cand,
  output cand_t                   o_best
);

  localparam int c_NODES = 2 * int'(SrcPerCycle) - 1;

  // Heap layout: node n has children 2n+1 (left) and 2n+2 (right); the
  // leaves sit at SrcPerCycle-1 and up in ascending id order.
  cand_t w_node [c_NODES];

  always_comb begin
    for (int k = 0; k < int'(SrcPerCycle); k++) begin
      w_node[int'(SrcPerCycle) - 1 + k] = i_cand[k];
    end
    for (int n = int'(SrcPerCycle) - 2; n >= 0; n--) begin
      w_node[n] = better(w_node[2*n+2], w_node[2*n+1]) ? w_node[2*n+2]
                                                       : w_node[2*n+1];
    end
  end

  assign o_best = w_node[0];

endmodule
`default_nettype wire

// File: rtl/clic_irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : clic_irq_arbiter
// Purpose  : Sequential CLIC interrupt arbiter. Sweeps the sources one slice
//            per cycle, keeps the best eligible candidate, offers the sweep
//            winner to the core with valid/ready and withdraws a stale offer
//            with a kill request/ack handshake.
// Ports    : clk_i, rst_i      - clock, asynchronous active-high reset
//            ip_i, ie_i        - pending / enable per source
//            level_i, priv_i   - level / target privilege per source
//            shv_i             - selective hardware vectoring per source
//            threshold_i       - effective threshold, eligible when level > it
//            irq_valid_o/irq_ready_i - offer handshake
//            irq_id_o, irq_level_o, irq_priv_o, irq_shv_o - offered candidate
//            irq_kill_req_o/irq_kill_ack_i - withdrawal handshake
//            claim_o, claim_id_o - one-cycle pulse and id of a taken offer
// Macro    : CLIC_ARB_PRIV_EN - privilege joins the ranking and drives
//            irq_priv_o; otherwise priv_i is ignored and irq_priv_o = 2'b11
// Revision : 1.0 - initial release
// ============================================================================
module clic_irq_arbiter
  import clic_arb_pkg::*;
#(
  parameter int unsigned NumSrc      = c_NUM_SRC,
  parameter int unsigned SrcPerCycle = 8,
  parameter int unsigned LevelWidth  = c_LEVEL_W,
  parameter int unsigned IdWidth     = $clog2(NumSrc)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumSrc-1:0]            ip_i,
  input  logic [NumSrc-1:0]            ie_i,
  input  logic [NumSrc*LevelWidth-1:0] level_i,
  input  logic [NumSrc*2-1:0]          priv_i,
  input  logic [NumSrc-1:0]            shv_i,
  input  logic [LevelWidth-1:0]        threshold_i,
  output logic                         irq_valid_o,
  input  logic                         irq_ready_i,
  output logic [IdWidth-1:0]           irq_id_o,
  output logic [LevelWidth-1:0]        irq_level_o,
  output logic [1:0]                   irq_priv_o,
  output logic                         irq_shv_o,
  output logic                         irq_kill_req_o,
  input  logic                         irq_kill_ack_i,
  output logic                         claim_o,
  output logic [IdWidth-1:0]           claim_id_o
);

  localparam int unsigned c_NUM_SLICE = NumSrc / SrcPerCycle;
  localparam int unsigned c_IDX_W     = (c_NUM_SLICE > 1) ? $clog2(c_NUM_SLICE) : 1;

  arb_state_e             r_state;
  arb_state_e             w_state_nxt;
  logic [c_IDX_W-1:0]     r_idx;
  cand_t                  r_best;
  logic [IdWidth-1:0]     r_id;
  logic [LevelWidth-1:0]  r_level;
  logic                   r_shv;
  logic                   r_claim;
  logic [IdWidth-1:0]     r_claim_id;

  cand_t [SrcPerCycle-1:0] w_cand;
  cand_t                   w_slice;
  cand_t                   w_merged;
  logic                    w_last;
  logic                    w_take;
  logic                    w_restart;
  logic                    w_load;

  // --------------------------------------------------------------------------
  // Per-source field views, so the slice can index by source id directly
  // --------------------------------------------------------------------------
  logic [LevelWidth-1:0] w_lvl_arr [NumSrc];

  for (genvar n = 0; n < int'(NumSrc); n++) begin : g_lvl_unpack
    assign w_lvl_arr[n] = level_i[n*LevelWidth +: LevelWidth];
  end

`ifdef CLIC_ARB_PRIV_EN
  logic [1:0] w_priv_arr [NumSrc];

  for (genvar n = 0; n < int'(NumSrc); n++) begin : g_priv_unpack
    assign w_priv_arr[n] = priv_i[n*2 +: 2];
  end
`endif

  // --------------------------------------------------------------------------
  // Slice candidates: inputs are sampled live, nothing is snapshotted
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < int'(SrcPerCycle); k++) begin : g_cand
    logic [IdWidth-1:0] w_src;

    assign w_src             = IdWidth'(32'(r_idx) * SrcPerCycle + k);
    assign w_cand[k].valid   = ip_i[w_src] & ie_i[w_src] & (w_lvl_arr[w_src] > threshold_i);
    assign w_cand[k].id      = w_src;
    assign w_cand[k].level   = w_lvl_arr[w_src];
`ifdef CLIC_ARB_PRIV_EN
    assign w_cand[k].priv    = w_priv_arr[w_src];
`else
    assign w_cand[k].priv    = 2'b11;
`endif
    assign w_cand[k].shv     = shv_i[w_src];
  end

  clic_slice_max #(
    .SrcPerCycle (SrcPerCycle)
  ) u_slice_max (
    .i_cand (w_cand),
    .o_best (w_slice)
  );

  // Earlier slices hold lower ids, so on a full tie the running best stays.
  assign w_merged = better(w_slice, r_best) ? w_slice : r_best;
  assign w_last   = (r_idx == c_IDX_W'(c_NUM_SLICE - 1));

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_SCAN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_restart   = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      ST_SCAN: begin
        if (w_last && w_merged.valid) begin
          w_load      = 1'b1;
          w_state_nxt = ST_OFFER;
        end
      end
      ST_OFFER: begin
        // A take beats a sweep end that lands in the same cycle.
        if (irq_ready_i) begin
          w_take      = 1'b1;
          w_restart   = 1'b1;
          w_state_nxt = ST_SCAN;
        end else if (w_last && (!w_merged.valid || (w_merged.id != r_id))) begin
          w_state_nxt = ST_KILL;
        end
      end
      ST_KILL: begin
        // A late take still counts as a claim and wins over the ack.
        if (irq_ready_i) begin
          w_take      = 1'b1;
          w_restart   = 1'b1;
          w_state_nxt = ST_SCAN;
        end else if (irq_kill_ack_i) begin
          w_restart   = 1'b1;
          w_state_nxt = ST_SCAN;
        end
      end
      default: begin
        w_state_nxt = ST_SCAN;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Sweep counter, running best and offer/claim registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_idx      <= '0;
      r_best     <= '0;
      r_id       <= '0;
      r_level    <= '0;
      r_shv      <= 1'b0;
      r_claim    <= 1'b0;
      r_claim_id <= '0;
    end else begin
      if (w_restart || w_last) begin
        r_idx  <= '0;
        r_best <= '0;
      end else begin
        r_idx  <= r_idx + c_IDX_W'(1);
        r_best <= w_merged;
      end
      if (w_load) begin
        r_id    <= w_merged.id;
        r_level <= w_merged.level;
        r_shv   <= w_merged.shv;
      end
      r_claim <= w_take;
      if (w_take) begin
        r_claim_id <= r_id;
      end
    end
  end

`ifdef CLIC_ARB_PRIV_EN
  logic [1:0] r_priv;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_priv <= 2'b00;
    end else if (w_load) begin
      r_priv <= w_merged.priv;
    end
  end

  assign irq_priv_o = r_priv;
`else
  // Privilege does not take part; everything is presented as M-mode.
  logic w_unused_priv;
  assign w_unused_priv = ^{priv_i, w_merged.priv};
  assign irq_priv_o    = 2'b11;
`endif

  assign irq_valid_o    = (r_state != ST_SCAN);
  assign irq_kill_req_o = (r_state == ST_KILL);
  assign irq_id_o       = r_id;
  assign irq_level_o    = r_level;
  assign irq_shv_o      = r_shv;
  assign claim_o        = r_claim;
  assign claim_id_o     = r_claim_id;

endmodule
`default_nettype wire
